npu_dpram_avalon: RTL
=====================

# npu_dpram_avalon

Parametrised true dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) sharing one clock. It is the next-generation scratchpad for the NPU fabric, replacing fixed 16-bit × 4096 RAMs. It adds configurable width and depth, pipelined reads with `readdatavalid`, and deterministic write-collision arbitration with fairness. Mixed-port read-during-write returns new data, and an optional hardware clear-on-reset sequencer removes the need for an init file.

## Interface
- `DATA_W`, 16, word width; multiple of 8.
- `ADDR_W`, 12, address width; depth is 2^ADDR_W words.
- `READ_LATENCY`, 1, read latency in cycles; legal values 1 or 2.
- `CLEAR_ON_RESET`, 1, 1 = write `CLEAR_VALUE` to every word after reset.
- `CLEAR_VALUE`, 0, `DATA_W`-bit fill word.
- `clk`  in  1  single clock for both ports.
- `reset`  in  1  synchronous, active-high reset.
- `chipselect`, `read`, `write`  in  1 each  port s1 controls.
- `address`  in  ADDR_W  port s1 word address.
- `byteenable`  in  DATA_W/8  port s1 byte lanes.
- `writedata`  in  DATA_W  port s1 write data.
- `readdata`  out  DATA_W  port s1 read data.
- `readdatavalid`  out  1  port s1 read data valid, one-cycle pulse.
- `waitrequest`  out  1  port s1 stall.
- `chipselect2`, `read2`, `write2`, `address2`, `byteenable2`, `writedata2`, `readdata2`, `readdatavalid2`, `waitrequest2`: port s2, same widths and meanings.
- `init_busy`  out  1  clear sequence in progress.

## Operation
- State machine states:
  - CLEAR: entered from reset when `CLEAR_ON_RESET`=1. An ADDR_W-bit counter runs 0 to 2^ADDR_W−1 and writes `CLEAR_VALUE` with all byte lanes enabled, one word per cycle. After the last address is written, the block moves to RUN.
  - RUN: entered directly from reset when `CLEAR_ON_RESET`=0.
- Behaviour in CLEAR:
  - `init_busy`=1.
  - `waitrequest`=`waitrequest2`=1 whenever the port is selected (`chipselect`=1); 0 otherwise.
  - No transfer is accepted.
- Reset asserted mid-CLEAR restarts the counter at 0.
- Accept rule: a port access is accepted on a rising edge when `chipselect`=1, `read` or `write` is 1, and `waitrequest`=0.
- If `read` and `write` are both 1 on one port, the access is a write only and produces no `readdatavalid`.
- Writes update only the lanes whose `byteenable` bit is 1.
- Collision: both ports write the same address in the same cycle.
  - Without priority, s1 wins; `waitrequest2`=1 and the s2 write is not performed that cycle.
  - On any stall, the fairness flop `pri2` is set. While `pri2`=1, s2 wins the next collision and s1 is stalled instead.
  - `pri2` clears when s2 completes the write.
  - A master that is stalled completes its write within 2 cycles.
  - Writes to different addresses never stall.
- Mixed-port read-during-write: when one port reads an address that the other port writes in the same cycle, the read returns the newly written bytes merged with the old contents of the disabled lanes (forwarding path).
- Reads never stall in RUN.
- Between valid pulses, `readdata` and `readdata2` hold their last value.

## Timing
- Reset values:
  - `readdata`, `readdata2` = 0.
  - `readdatavalid`, `readdatavalid2` = 0.
  - `pri2` = 0.
  - `init_busy` = `CLEAR_ON_RESET`.
- `waitrequest` and `waitrequest2` are combinational from the current inputs, the state and `pri2`.
- Read latency: a read accepted at edge N presents data with `readdatavalid`=1 in the cycle after edge N+`READ_LATENCY`.
- Throughput: full pipelining, one read per cycle per port, with no bubbles.
- Write then read of the same address on consecutive cycles, from either port, returns the new data.
- Clear duration: `init_busy` is high for exactly 2^ADDR_W cycles after the first edge with `reset`=0. The first access is accepted on the edge after `init_busy` falls.
- Reads in flight are killed by reset: `readdatavalid` is 0 in the cycle after reset is sampled.

## Test plan
- Clear: `CLEAR_ON_RESET`=1, `CLEAR_VALUE`=16'hA5A5, ADDR_W=4, then reset. Required:
  - `init_busy` high for 16 cycles.
  - A selected port sees `waitrequest`=1 during clear.
  - Reads of addresses 0 to 15 afterwards return 16'hA5A5.
- Pipelined read: `READ_LATENCY`=2; s1 reads addresses 0 to 7 back to back after writing value = address×3. Required: 8 consecutive `readdatavalid` pulses starting 2 cycles after the first accept, with data 0,3,…,21.
- Byte lanes: write 16'h1234 to address 5, then write 16'hFFFF to address 5 with `byteenable`=2'b10. Required: read returns 16'hFF34.
- Collision and fairness: s1 and s2 both write address 9 (s1 16'h1111, s2 16'h2222) and hold for 3 consecutive requests each. Required:
  - s2 stalled first, then completes.
  - Accept order alternates s1, s2, s1.
  - Final read returns the last accepted value.
  - Neither port is ever stalled more than 1 cycle in a row.
- Mixed read-during-write: s1 writes 16'hBEEF to address 3 (old contents 16'h0000) while s2 reads address 3 in the same cycle. Required: `readdata2`=16'hBEEF.
- Reset mid-operation:
  - Assert reset at clear count 7. Required: clear restarts at 0 and lasts a full 16 cycles.
  - Assert reset with 2 reads in flight. Required: no `readdatavalid` after reset.

Source files
------------

// File: rtl/npu_dpram_avalon.sv
// True dual-port scratchpad RAM with two Avalon-MM slave ports, pipelined reads,
// fair write-collision arbitration, mixed-port forwarding and an optional clear sequencer.
module npu_dpram_avalon #(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 12,
    parameter int                READ_LATENCY   = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    input  logic                chipselect2,
    input  logic                read2,
    input  logic                write2,
    input  logic [ADDR_W-1:0]   address2,
    input  logic [DATA_W/8-1:0] byteenable2,
    input  logic [DATA_W-1:0]   writedata2,
    output logic [DATA_W-1:0]   readdata2,
    output logic                readdatavalid2,
    output logic                waitrequest2,
    output logic                init_busy
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clear_cnt;
    logic              clear_we;
    logic              pri2;
    logic              run, wr1, wr2, collision;
    logic              wr1_acc, wr2_acc, rd1_acc, rd2_acc;
    logic [DATA_W-1:0] fwd1, fwd2;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NBYTES-1:0] lanes
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (lanes[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

    assign run       = (state == ST_RUN);
    assign wr1       = chipselect & write;
    assign wr2       = chipselect2 & write2;
    assign collision = wr1 & wr2 & (address == address2);

    always_comb begin
        state_next   = state;
        init_busy    = 1'b0;
        clear_we     = 1'b0;
        waitrequest  = 1'b0;
        waitrequest2 = 1'b0;
        if (state == ST_CLEAR) begin
            init_busy    = 1'b1;
            clear_we     = 1'b1;
            waitrequest  = chipselect;
            waitrequest2 = chipselect2;
            if (clear_cnt == '1) state_next = ST_RUN;
        end else begin
            // Only a same-address write pair stalls; pri2 decides which side waits.
            waitrequest  = collision & pri2;
            waitrequest2 = collision & ~pri2;
        end
    end

    assign wr1_acc = run & wr1 & ~waitrequest;
    assign wr2_acc = run & wr2 & ~waitrequest2;
    assign rd1_acc = run & chipselect & read & ~write & ~waitrequest;
    assign rd2_acc = run & chipselect2 & read2 & ~write2 & ~waitrequest2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clear_cnt <= '0;
            pri2      <= 1'b0;
        end else begin
            state <= state_next;
            if (clear_we) clear_cnt <= clear_cnt + ADDR_W'(1);
            if (wr2_acc)                   pri2 <= 1'b0;
            else if (run && waitrequest2)  pri2 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_we) mem[clear_cnt] <= CLEAR_VALUE;
        if (wr1_acc)  mem[address]   <= merge_bytes(mem[address], writedata, byteenable);
        if (wr2_acc)  mem[address2]  <= merge_bytes(mem[address2], writedata2, byteenable2);
    end

    // Mixed-port read-during-write sees the other port's new bytes over the old word.
    always_comb begin
        fwd1 = mem[address];
        if (wr2_acc && (address2 == address)) fwd1 = merge_bytes(fwd1, writedata2, byteenable2);
        fwd2 = mem[address2];
        if (wr1_acc && (address == address2)) fwd2 = merge_bytes(fwd2, writedata, byteenable);
    end

    // Stage p0: array read captured on the accept edge
    logic [DATA_W-1:0] rdata_p0, rdata2_p0;
    logic              vld_p0, vld2_p0;

    always_ff @(posedge clk) begin
        rdata_p0  <= fwd1;
        rdata2_p0 <= fwd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            vld2_p0 <= 1'b0;
        end else begin
            vld_p0  <= rd1_acc;
            vld2_p0 <= rd2_acc;
        end
    end

    // Stage p1: optional extra register for READ_LATENCY=2
    logic [DATA_W-1:0] rdata_last, rdata2_last;
    logic              vld_last, vld2_last;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] rdata_p1, rdata2_p1;
        logic              vld_p1, vld2_p1;

        always_ff @(posedge clk) begin
            rdata_p1  <= rdata_p0;
            rdata2_p1 <= rdata2_p0;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p1  <= 1'b0;
                vld2_p1 <= 1'b0;
            end else begin
                vld_p1  <= vld_p0;
                vld2_p1 <= vld2_p0;
            end
        end

        assign rdata_last  = rdata_p1;
        assign rdata2_last = rdata2_p1;
        assign vld_last    = vld_p1;
        assign vld2_last   = vld2_p1;
    end else begin : g_lat1
        assign rdata_last  = rdata_p0;
        assign rdata2_last = rdata2_p0;
        assign vld_last    = vld_p0;
        assign vld2_last   = vld2_p0;
    end

    // Output stage: readdata holds between valid pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata       <= '0;
            readdata2      <= '0;
            readdatavalid  <= 1'b0;
            readdatavalid2 <= 1'b0;
        end else begin
            readdatavalid  <= vld_last;
            readdatavalid2 <= vld2_last;
            if (vld_last)  readdata  <= rdata_last;
            if (vld2_last) readdata2 <= rdata2_last;
        end
    end

endmodule
